mem_port_arbiter: RTL

//  Shares one external 64-bit memory port between the core's instruction-fetch

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and data memory.
// Ports: IF req/addr -> inst/valid/stall, DM req/op -> rd_data/valid/stall,
//        memory req/wr_en/addr/wr_data <- ack/rd_data, err on timeout.
module mem_port_arbiter #(
  parameter int MAX_DM_BURST   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        in_Clk,
  input  logic        in_Rst,
  input  logic        in_if_req,
  input  logic [63:0] in_if_addr,
  output logic [31:0] out_if_inst,
  output logic        out_if_valid,
  output logic        out_if_stall,
  input  logic        in_dm_req,
  input  logic        in_dm_wr_en,
  input  logic [63:0] in_dm_addr,
  input  logic [63:0] in_dm_wr_data,
  output logic [63:0] out_dm_rd_data,
  output logic        out_dm_valid,
  output logic        out_dm_stall,
  output logic        out_mem_req,
  output logic        out_mem_wr_en,
  output logic [63:0] out_mem_addr,
  output logic [63:0] out_mem_wr_data,
  input  logic        in_mem_ack,
  input  logic [63:0] in_mem_rd_data,
  output logic        out_mem_err
);

  localparam logic [3:0] MAX_B    = 4'(MAX_DM_BURST);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state, state_nx;
  logic        win_dm, win_dm_nx;
  logic [63:0] addr_q, addr_nx;
  logic        wr_en_q, wr_en_nx;
  logic [63:0] wr_data_q, wr_data_nx;
  logic [3:0]  burst_q, burst_nx;
  logic [7:0]  tmo_q, tmo_nx;
  logic        err_q, err_nx;
  logic [31:0] inst_q, inst_nx;
  logic [63:0] dm_rd_q, dm_rd_nx;
  logic        grant_dm;
  logic        capture;
  logic [63:0] cap_data;

  assign grant_dm = in_dm_req & (~in_if_req | (burst_q < MAX_B));

  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      state     <= S_IDLE;
      win_dm    <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      burst_q   <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      inst_q    <= '0;
      dm_rd_q   <= '0;
    end else begin
      state     <= state_nx;
      win_dm    <= win_dm_nx;
      addr_q    <= addr_nx;
      wr_en_q   <= wr_en_nx;
      wr_data_q <= wr_data_nx;
      burst_q   <= burst_nx;
      tmo_q     <= tmo_nx;
      err_q     <= err_nx;
      inst_q    <= inst_nx;
      dm_rd_q   <= dm_rd_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    win_dm_nx  = win_dm;
    addr_nx    = addr_q;
    wr_en_nx   = wr_en_q;
    wr_data_nx = wr_data_q;
    burst_nx   = burst_q;
    tmo_nx     = tmo_q;
    err_nx     = err_q;
    inst_nx    = inst_q;
    dm_rd_nx   = dm_rd_q;
    capture    = 1'b0;
    cap_data   = '0;
    unique case (state)
      S_IDLE: begin
        if (in_if_req | in_dm_req) begin
          state_nx   = S_WAIT;
          win_dm_nx  = grant_dm;
          addr_nx    = grant_dm ? in_dm_addr : in_if_addr;
          wr_en_nx   = grant_dm & in_dm_wr_en;
          wr_data_nx = in_dm_wr_data;
          tmo_nx     = '0;
          err_nx     = 1'b0;
          // The run only counts DM grants that made a waiting IF lose.
          if (grant_dm && in_if_req)
            burst_nx = (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;
          else
            burst_nx = '0;
        end
      end
      S_WAIT: begin
        if (in_mem_ack) begin
          state_nx = S_RESP;
          capture  = 1'b1;
          cap_data = in_mem_rd_data;
        end else if (tmo_q == TMO_LAST) begin
          state_nx = S_RESP;
          capture  = 1'b1;
          err_nx   = 1'b1;
        end else begin
          tmo_nx = tmo_q + 8'd1;
        end
      end
      S_RESP: begin
        state_nx = S_IDLE;
        err_nx   = 1'b0;
      end
      default: state_nx = S_IDLE;
    endcase
    if (capture) begin
      if (!win_dm)
        inst_nx = addr_q[2] ? cap_data[63:32] : cap_data[31:0];
      else if (!wr_en_q)
        dm_rd_nx = cap_data;
    end
  end

  logic in_wait, in_resp;
  assign in_wait = (state == S_WAIT);
  assign in_resp = (state == S_RESP);

  assign out_mem_req     = in_wait;
  assign out_mem_wr_en   = in_wait & wr_en_q;
  assign out_mem_addr    = !in_wait ? '0 :
                           win_dm ? addr_q : {addr_q[63:3], 3'b000};
  assign out_mem_wr_data = in_wait ? wr_data_q : '0;
  assign out_mem_err     = in_resp & err_q;
  assign out_if_valid    = in_resp & ~win_dm;
  assign out_dm_valid    = in_resp & win_dm;
  assign out_if_inst     = inst_q;
  assign out_dm_rd_data  = dm_rd_q;
  assign out_if_stall    = in_if_req & ~out_if_valid;
  assign out_dm_stall    = in_dm_req & ~out_dm_valid;

endmodule
